// File: rtl/dist_arbiter_pkg.sv
// dist_arbiter_pkg: shared FSM encoding and constants for dist_arbiter
//   state_t  - arbiter FSM states
//   PT_W     - width of one {x,y,z} single-precision point
//   NAN_F32  - quiet NaN loaded into res on a timed-out operation
package dist_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    localparam int PT_W = 96;
    localparam logic [31:0] NAN_F32 = 32'h7FC00000;
endpackage

// File: rtl/dist_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin selector with last-grant pointer
//   CLK    in  clock
//   RST    in  asynchronous active-low reset, pointer resets to 1
//   req    in  {req1, req0}
//   upd    in  load the pointer with upd_id
//   upd_id in  requester that was just served
//   sel    out winning requester (0/1), meaningful only when req != 0
module rr_arb2 (
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] req,
    input  logic       upd,
    input  logic       upd_id,
    output logic       sel
);
    logic last;
    always_ff @(posedge CLK or negedge RST)
        if (!RST) last <= 1'b1;
        else if (upd) last <= upd_id;
    // with both requesting, the one not served last wins
    assign sel = (req[0] && req[1]) ? ~last : req[1];
endmodule

// File: rtl/dist_arbiter.sv
// dist_arbiter: two-requester round-robin front end for a shared distance core
//   CLK, RST            clock, asynchronous active-low reset
//   req0/req1           level requests; pa*/pb* operand points sampled at grant
//   gnt0/gnt1           high while that requester's operation is in flight
//   done0/done1         one-cycle result pulse (suppressed if req dropped)
//   res                 shared result, held until the next completion
//   err                 timeout pulse with done (DIST_TIMEOUT_EN only, else 0)
//   dc_rst_n            core start/clear, low except during WAIT
//   dc_a/dc_b, dc_res, dc_rdy  distance core interface
// Macro DIST_TIMEOUT_EN enables the WAIT timeout (TIMEOUT_CYCLES).
module dist_arbiter
    import dist_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int RST_LOW_CYCLES = 2
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            req0,
    input  logic            req1,
    input  logic [PT_W-1:0] pa0,
    input  logic [PT_W-1:0] pb0,
    input  logic [PT_W-1:0] pa1,
    input  logic [PT_W-1:0] pb1,
    output logic            gnt0,
    output logic            gnt1,
    output logic            done0,
    output logic            done1,
    output logic [31:0]     res,
    output logic            err,
    output logic            dc_rst_n,
    output logic [PT_W-1:0] dc_a,
    output logic [PT_W-1:0] dc_b,
    input  logic [31:0]     dc_res,
    input  logic            dc_rdy
);
    localparam int RC_W = RST_LOW_CYCLES > 1 ? $clog2(RST_LOW_CYCLES) : 1;
    state_t st;
    logic cur, sel, tmo;
    logic [RC_W-1:0] rcnt;
    rr_arb2 u_arb (
        .CLK    (CLK),
        .RST    (RST),
        .req    ({req1, req0}),
        .upd    (st == DONE),
        .upd_id (cur),
        .sel    (sel)
    );
`ifdef DIST_TIMEOUT_EN
    localparam int TC_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TC_W-1:0] tcnt;
    assign tmo = !dc_rdy && tcnt == TC_W'(TIMEOUT_CYCLES - 1);
`else
    assign tmo = 1'b0;
    assign err = 1'b0;
`endif
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            st       <= IDLE;
            cur      <= 1'b0;
            rcnt     <= '0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            done0    <= 1'b0;
            done1    <= 1'b0;
            res      <= '0;
            dc_rst_n <= 1'b0;
            dc_a     <= '0;
            dc_b     <= '0;
`ifdef DIST_TIMEOUT_EN
            err      <= 1'b0;
            tcnt     <= '0;
`endif
        end else begin
            done0 <= 1'b0;
            done1 <= 1'b0;
`ifdef DIST_TIMEOUT_EN
            err   <= 1'b0;
`endif
            case (st)
                IDLE: if (req0 || req1) begin
                    cur  <= sel;
                    gnt0 <= !sel;
                    gnt1 <= sel;
                    dc_a <= sel ? pa1 : pa0;
                    dc_b <= sel ? pb1 : pb0;
                    rcnt <= '0;
`ifdef DIST_TIMEOUT_EN
                    tcnt <= '0;
`endif
                    st   <= ISSUE;
                end
                // dc_rdy is deliberately not looked at here: it may still be
                // high from the previous operation until the clear takes hold
                ISSUE: if (rcnt == RC_W'(RST_LOW_CYCLES - 1)) begin
                    dc_rst_n <= 1'b1;
                    st       <= WAIT;
                end else rcnt <= rcnt + RC_W'(1);
                WAIT: begin
                    if (dc_rdy || tmo) begin
                        res      <= dc_rdy ? dc_res : NAN_F32;
                        done0    <= !cur && req0;
                        done1    <= cur && req1;
                        dc_rst_n <= 1'b0;
                        st       <= DONE;
                    end
`ifdef DIST_TIMEOUT_EN
                    err  <= tmo && (cur ? req1 : req0);
                    tcnt <= tcnt + TC_W'(1);
`endif
                end
                DONE: begin
                    gnt0 <= 1'b0;
                    gnt1 <= 1'b0;
                    st   <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dist_arbiter.sv
// tb_dist_arbiter: scoreboard bench for dist_arbiter with a behavioural distance core
module tb_dist_arbiter;
    import dist_arbiter_pkg::*;
    localparam int RLC = 2;
    localparam int TOC = 8;
    typedef struct {logic id; logic [31:0] r; logic e;} exp_t;
    logic CLK = 0, RST = 0, req0 = 0, req1 = 0;
    logic [95:0] pa0 = '0, pb0 = '0, pa1 = '0, pb1 = '0;
    logic gnt0, gnt1, done0, done1, err, dc_rst_n, dc_rdy;
    logic [31:0] res, dc_res;
    logic [95:0] dc_a, dc_b;
    bit stale = 0, mutex_bad = 0;
    int lat = 10, cnt = 0, pass_n = 0, tot_n = 0, c, w;
    exp_t q[$];
    exp_t e;
    always #5 CLK = ~CLK;
    dist_arbiter #(.TIMEOUT_CYCLES(TOC), .RST_LOW_CYCLES(RLC)) dut (
        .CLK(CLK), .RST(RST), .req0(req0), .req1(req1),
        .pa0(pa0), .pb0(pb0), .pa1(pa1), .pb1(pb1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .res(res), .err(err), .dc_rst_n(dc_rst_n), .dc_a(dc_a), .dc_b(dc_b),
        .dc_res(dc_res), .dc_rdy(dc_rdy)
    );
    function automatic logic [31:0] h(logic [95:0] a, logic [95:0] b);
        if (a == {32'h40400000, 32'h40800000, 32'h0} && b == '0) return 32'h40A00000;
        return a[95:64] ^ {a[47:32], a[63:48]} ^ (a[31:0] + b[95:64]) ^ (b[63:32] - b[31:0]);
    endfunction
    // core: ready lat cycles after its clear is released, or stuck ready in stale mode;
    // while held cleared it presents a recognisable stale value
    always @(posedge CLK) cnt <= dc_rst_n ? (cnt < 100000 ? cnt + 1 : cnt) : 0;
    assign dc_rdy = stale || cnt >= lat;
    assign dc_res = dc_rst_n ? h(dc_a, dc_b) : 32'hDEAD0001;
    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        tot_n++;
        if (got === exp) pass_n++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask
    task automatic push(input logic id, input logic [31:0] r, input logic er);
        exp_t x;
        x.id = id; x.r = r; x.e = er;
        q.push_back(x);
    endtask
    task automatic wait_done(input string tag, input int budget, output int cy);
        cy = 0;
        do begin
            @(posedge CLK); #1;
            cy++;
        end while (!(done0 || done1) && cy < budget);
        if (!(done0 || done1)) check(tag, 0, 1);
    endtask
    task automatic wait_run(input string tag);
        int k = 0;
        while (!dc_rst_n && k < 50) begin
            @(posedge CLK); #1;
            k++;
        end
        if (!dc_rst_n) check(tag, 0, 1);
    endtask
    always @(negedge CLK) begin
        if (gnt0 && gnt1) mutex_bad <= 1;
        if (done0 || done1) begin
            if (q.size() == 0) check("spurious_done", {94'b0, done1, done0}, 0);
            else begin
                e = q.pop_front();
                check("done_id", {94'b0, done1, done0}, e.id ? 96'd2 : 96'd1);
                check("res", {64'b0, res}, {64'b0, e.r});
                check("err", {95'b0, err}, {95'b0, e.e});
            end
        end else if (err) check("err_without_done", 1, 0);
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
    initial begin
        pa0 = {$urandom, $urandom, $urandom}; pb0 = {$urandom, $urandom, $urandom};
        pa1 = {$urandom, $urandom, $urandom}; pb1 = {$urandom, $urandom, $urandom};
        req0 = 1; req1 = 1;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_gnt", {gnt1, gnt0}, 0);
        check("rst_done", {done1, done0}, 0);
        check("rst_err", err, 0);
        check("rst_res", res, 0);
        check("rst_dc_rst_n", dc_rst_n, 0);
        check("rst_dc_a", dc_a, 0);
        check("rst_dc_b", dc_b, 0);
        // contention from reset: 0,1,0,1
        push(0, h(pa0, pb0), 0); push(1, h(pa1, pb1), 0);
        push(0, h(pa0, pb0), 0); push(1, h(pa1, pb1), 0);
        lat = 3;
        RST = 1;
        for (int i = 0; i < 4; i++) wait_done("contention_timeout", 60, c);
        req0 = 0; req1 = 0;
        repeat (4) @(posedge CLK);
        #1;
        check("contention_idle", {gnt1, gnt0}, 0);
        // single request, 3-4-0 triangle
        pa0 = {32'h40400000, 32'h40800000, 32'h0}; pb0 = '0; lat = 10;
        push(0, 32'h40A00000, 0);
        req0 = 1;
        @(posedge CLK); #1;
        check("single_gnt", {gnt1, gnt0}, 2'b01);
        check("single_dc_a", dc_a, pa0);
        w = 0;
        while (!dc_rst_n && w < 20) begin
            w++;
            @(posedge CLK); #1;
        end
        check("issue_low_cycles", w, RLC);
        wait_done("single_timeout", 100, c);
        check("single_wait_cycles", c, lat + 1);
        req0 = 0;
        @(posedge CLK); #1;
        check("done_one_cycle", done0, 0);
        check("gnt_dropped", gnt0, 0);
        check("res_held", res, 32'h40A00000);
        // stale ready across back-to-back ops
        stale = 1;
        pa0 = {$urandom, $urandom, $urandom}; pb0 = {$urandom, $urandom, $urandom};
        push(0, h(pa0, pb0), 0);
        req0 = 1;
        wait_done("stale1_timeout", 50, c);
        pa0 = {$urandom, $urandom, $urandom}; pb0 = {$urandom, $urandom, $urandom};
        push(0, h(pa0, pb0), 0);
        wait_done("stale2_timeout", 50, c);
        check("stale_done_gap", c, RLC + 3);
        req0 = 0; stale = 0;
        repeat (2) @(posedge CLK);
        // abandon: req1 drops during WAIT
        pa1 = {$urandom, $urandom, $urandom}; pb1 = {$urandom, $urandom, $urandom};
        lat = 6;
        req1 = 1;
        wait_run("abandon_run_timeout");
        req1 = 0;
        w = 0;
        while (gnt1 && w < 50) begin
            w++;
            @(posedge CLK); #1;
        end
        check("abandon_idle", gnt1, 0);
        check("abandon_res", res, h(pa1, pb1));
        // timeout
        lat = 100000;
        pa0 = {$urandom, $urandom, $urandom};
        req0 = 1;
        wait_run("timeout_run_timeout");
        w = 0;
`ifdef DIST_TIMEOUT_EN
        push(0, NAN_F32, 1);
        while (dc_rst_n && w < 60) begin
            w++;
            @(posedge CLK); #1;
        end
        check("timeout_wait_cycles", w, TOC);
        check("timeout_done", {done1, done0, err}, 3'b011);
        req0 = 0;
`else
        while (dc_rst_n && !done0 && !err && w < 60) begin
            w++;
            @(posedge CLK); #1;
        end
        check("no_timeout_wait", w, 60);
        check("no_timeout_done", {done0, err}, 0);
        req0 = 0;
        RST = 0;
        @(posedge CLK); #1;
        RST = 1;
`endif
        repeat (2) @(posedge CLK);
        #1;
        // quick req0 op so the pointer last served requester 0
        lat = 2;
        pa0 = {$urandom, $urandom, $urandom};
        push(0, h(pa0, pb0), 0);
        req0 = 1;
        wait_done("quick_timeout", 50, c);
        req0 = 0;
        repeat (2) @(posedge CLK);
        #1;
        // mid-op reset during req1 WAIT
        lat = 100000;
        req1 = 1;
        wait_run("midop_run_timeout");
        @(posedge CLK); #3;
        RST = 0;
        #1;
        check("midop_gnt", {gnt1, gnt0}, 0);
        check("midop_dc_rst_n", dc_rst_n, 0);
        check("midop_res", res, 0);
        check("midop_dc_a", dc_a, 0);
        check("midop_done", {done1, done0}, 0);
        lat = 4;
        pa0 = {$urandom, $urandom, $urandom}; pa1 = {$urandom, $urandom, $urandom};
        push(0, h(pa0, pb0), 0); push(1, h(pa1, pb1), 0);
        req0 = 1;
        @(posedge CLK); #1;
        RST = 1;
        wait_done("post_rst1_timeout", 60, c);
        req0 = 0;
        wait_done("post_rst2_timeout", 60, c);
        req1 = 0;
        repeat (4) @(posedge CLK);
        #1;
        check("mutex", mutex_bad, 0);
        check("queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", pass_n, tot_n);
        $finish;
    end
endmodule

// File: doc/dist_arbiter.md
DIST_ARBITER -- requirements
Module: dist_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, is the wait-cycle limit for one distance operation (used only with DIST_TIMEOUT_EN).
REQ-002 Parameter RST_LOW_CYCLES, default 2, is the number of cycles dc_rst_n is held low per issue.
REQ-003 CLK  in  1  single clock; all state changes on the rising edge.
REQ-004 RST  in  1  reset; asynchronous assert, active-low.
REQ-005 req0, req1  in  1 each  requester operation request, level.
REQ-006 pa0, pb0, pa1, pb1  in  96 each  operand points {x,y,z}, IEEE-754 single, x in [95:64].
REQ-007 gnt0, gnt1  out  1 each  high while that requester's operation is in flight.
REQ-008 done0, done1  out  1 each  one-cycle result-valid pulse.
REQ-009 res  out  32  shared result register, valid in the done-pulse cycle and held until the next done.
REQ-010 err  out  1  one-cycle pulse coincident with a done pulse on timeout.
REQ-011 dc_rst_n  out  1  start/clear to the distance core, active-low.
REQ-012 dc_a, dc_b  out  96 each  registered operands to the distance core.
REQ-013 dc_res  in  32  distance core result.
REQ-014 dc_rdy  in  1  distance core ready, level, cleared only by dc_rst_n low.

Function
REQ-015 The FSM SHALL have the states IDLE, ISSUE, WAIT and DONE.
REQ-016 IDLE: when any req is high, the block SHALL grant one requester by round-robin, latch that requester's operands into dc_a/dc_b, assert its gnt and go to ISSUE in the next cycle.
REQ-017 Round-robin: if both requests are high, the requester not granted last SHALL win; the last-grant pointer SHALL reset to 1 so that req0 wins first.
REQ-018 ISSUE: dc_rst_n SHALL be low for exactly RST_LOW_CYCLES cycles, then go high, and the FSM SHALL enter WAIT.
REQ-019 WAIT: the first cycle with dc_rdy high SHALL load dc_res into res and move the FSM to DONE.
REQ-020 dc_rdy SHALL be ignored in ISSUE, because it is stale from the previous operation.
REQ-021 DONE: the block SHALL pulse done for the granted requester for one cycle, deassert gnt, update the last-grant pointer and return to IDLE.
REQ-022 The minimum latency from req rising to done SHALL be RST_LOW_CYCLES + 3 cycles plus the core latency.
REQ-023 A requester SHALL keep req high until its done pulse; operands are sampled only at grant.
REQ-024 If the granted req drops before done, the operation SHALL complete, res SHALL update and the done pulse SHALL be suppressed.
REQ-025 A requester whose req is still high after its done SHALL be treated as a new request, subject to round-robin.
REQ-026 In IDLE the block SHALL never grant both requesters; gnt0 and gnt1 SHALL be mutually exclusive at all times.
REQ-027 A new request and a done occurring in the same cycle SHALL be arbitrated in the following IDLE cycle, which gives one idle cycle between operations.

Reset
REQ-028 While RST is low: FSM = IDLE, gnt/done/err = 0, res = 0, dc_a/dc_b = 0, dc_rst_n = 0, last-grant pointer = 1, timeout counter = 0.
REQ-029 Reset asserted mid-operation SHALL abort the operation with no done pulse; after RST rises, arbitration SHALL restart from the reset state.
REQ-030 dc_rst_n SHALL stay low in IDLE, so the core is always held cleared between operations.

Configuration
REQ-031 The macro DIST_TIMEOUT_EN SHALL control the timeout feature.
REQ-032 With DIST_TIMEOUT_EN defined, a counter SHALL count WAIT cycles.
REQ-033 When the counter reaches TIMEOUT_CYCLES without dc_rdy, res SHALL load 32'h7FC00000, the FSM SHALL go to DONE, and err SHALL pulse with done.
REQ-034 The counter SHALL clear on entry to ISSUE.
REQ-035 Without DIST_TIMEOUT_EN, WAIT SHALL wait indefinitely, err SHALL be tied 0 and no counter logic SHALL exist.

Structure
REQ-036 A shared package SHALL hold the FSM state encoding, the NaN constant 32'h7FC00000 and the point-width constant (96).
REQ-037 One sub-module, rr_arb2, SHALL implement the two-way round-robin grant and the last-grant pointer; the FSM, operand registers and timeout counter SHALL stay in dist_arbiter.

Verification
REQ-038 Single request: req0=1, pa0={3.0,4.0,0.0}, pb0=0, core model returns 5.0 (32'h40A00000) after 10 cycles -> gnt0 high, dc_rst_n low 2 cycles, done0 one pulse, res=32'h40A00000, err=0.
REQ-039 Contention: req0 and req1 high together from reset -> service order 0,1,0,1; gnt0 and gnt1 never high together.
REQ-040 Abandon: req1 drops during WAIT -> res updates, no done1 pulse, FSM returns to IDLE.
REQ-041 Mid-op reset: RST low during WAIT -> all outputs at reset values within the same cycle (asynchronous), no done pulse; next req0 is granted first.
REQ-042 Timeout (DIST_TIMEOUT_EN, TIMEOUT_CYCLES=8): dc_rdy held 0 -> after 8 WAIT cycles, done and err pulse together, res=32'h7FC00000; without the macro, the bench sees no done and err stays 0.
REQ-043 Stale ready: dc_rdy held high across back-to-back ops -> second result sampled only after the ISSUE phase, never in the first post-grant cycles.
